// File: rtl/servo_waypoint_sequencer.sv
// Waypoint sequencer for the servo controller: queues target angles and walks the
// controller through them, detecting arrival (settle window), dwell and move timeout.
module servo_waypoint_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TOL     = 2,
   parameter int SETTLE  = 16,
   parameter int TIMEOUT = 2**24-1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wp_valid,
   output logic                     wp_ready,
   input  logic [11:0]              wp_angle,
   input  logic [1:0]               wp_mode,
   input  logic [7:0]               wp_period,
   input  logic [15:0]              wp_dwell,
   input  logic                     start,
   input  logic                     abort,
   input  logic [31:0]              status_reg,
   output logic [31:0]              ctrl_reg,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(SETTLE + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int EW = 12 + 2 + 8 + 16;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MOVE, S_DWELL} state_t;

   state_t          state, state_nxt;
   logic [EW-1:0]   fifo_mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            push, pop, flush;
   logic [11:0]     head_angle;
   logic [1:0]      head_mode;
   logic [7:0]      head_period;
   logic [15:0]     head_dwell;
   logic [11:0]     tgt_angle, src_angle;
   logic [1:0]      tgt_mode, src_mode;
   logic [7:0]      tgt_period, src_period;
   logic [15:0]     tgt_dwell;
   logic            toggle, cmd_lo, src_cmd_lo;
   logic [SW-1:0]   settle_cnt, settle_nxt;
   logic [TW-1:0]   tmo_cnt, tmo_nxt;
   logic [15:0]     dwell_cnt, dwell_nxt;
   logic            in_win, done_nxt, err_nxt;
   logic [31:0]     ctrl_nxt;
   logic            unused_status_bits;

   function automatic logic [11:0] sat_angle(input logic [11:0] a);
      return (a > 12'd1005) ? 12'd1005 : a;
   endfunction

   // Shortest distance on the 0..1005 circle.
   function automatic logic [11:0] circ_dist(input logic [11:0] cur, input logic [11:0] tgt);
      logic [11:0] d;
      d = (cur >= tgt) ? cur - tgt : tgt - cur;
      if (d > 12'd503)
         d = 12'd1006 - d;
      return d;
   endfunction

   assign unused_status_bits = ^status_reg[31:12];
   assign wp_ready = (fifo_count < CW'(DEPTH)) && !abort;
   assign push     = wp_valid && wp_ready;
   assign {head_angle, head_mode, head_period, head_dwell} = fifo_mem[rd_ptr];
   assign in_win   = circ_dist(status_reg[11:0], tgt_angle) <= 12'(TOL);

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;
      flush      = 1'b0;
      pop        = 1'b0;
      settle_nxt = settle_cnt;
      tmo_nxt    = tmo_cnt;
      dwell_nxt  = dwell_cnt;
      case (state)
         S_IDLE: begin
            if (start && fifo_count != '0)
               state_nxt = S_LOAD;
         end
         S_LOAD: begin
            pop        = 1'b1;
            settle_nxt = '0;
            tmo_nxt    = '0;
            dwell_nxt  = '0;
            state_nxt  = S_MOVE;
         end
         S_MOVE: begin
            tmo_nxt    = tmo_cnt + TW'(1);
            settle_nxt = in_win ? settle_cnt + SW'(1) : '0;
            // Arrival is checked first so it wins a tie with the timeout.
            if (in_win && settle_cnt == SW'(SETTLE - 1)) begin
               dwell_nxt = '0;
               state_nxt = S_DWELL;
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
               err_nxt   = 1'b1;
               flush     = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         S_DWELL: begin
            if (dwell_cnt == tgt_dwell) begin
               if (fifo_count != '0) begin
                  state_nxt = S_LOAD;
               end else begin
                  done_nxt  = 1'b1;
                  state_nxt = S_IDLE;
               end
            end else begin
               dwell_nxt = dwell_cnt + 16'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (abort) begin
         state_nxt = S_IDLE;
         done_nxt  = 1'b0;
         err_nxt   = 1'b0;
         flush     = 1'b1;
         pop       = 1'b0;
      end

      src_angle  = pop ? head_angle  : tgt_angle;
      src_mode   = pop ? head_mode   : tgt_mode;
      src_period = pop ? head_period : tgt_period;
      src_cmd_lo = pop ? toggle      : cmd_lo;
      // LOAD keeps the previous word so the controller never sees a power-off glitch.
      case (state_nxt)
         S_IDLE:  ctrl_nxt = {20'd0, src_angle};
         S_LOAD:  ctrl_nxt = ctrl_reg;
         default: ctrl_nxt = {1'b1, 1'b1, src_cmd_lo, src_mode, 7'd0, src_period, src_angle};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_reg   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         settle_cnt <= '0;
         tmo_cnt    <= '0;
         dwell_cnt  <= '0;
         tgt_angle  <= '0;
         tgt_mode   <= '0;
         tgt_period <= '0;
         tgt_dwell  <= '0;
         toggle     <= 1'b0;
         cmd_lo     <= 1'b0;
      end else begin
         ctrl_reg   <= ctrl_nxt;
         busy       <= (state_nxt != S_IDLE);
         done       <= done_nxt;
         error      <= err_nxt;
         settle_cnt <= settle_nxt;
         tmo_cnt    <= tmo_nxt;
         dwell_cnt  <= dwell_nxt;
         if (pop) begin
            tgt_angle  <= head_angle;
            tgt_mode   <= head_mode;
            tgt_period <= head_period;
            tgt_dwell  <= head_dwell;
            cmd_lo     <= toggle;
            toggle     <= ~toggle;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= {sat_angle(wp_angle), wp_mode, wp_period, wp_dwell};
   end

endmodule

// File: tb/tb_servo_waypoint_sequencer.sv
// Scoreboard bench for servo_waypoint_sequencer: waypoints queued at push time are
// compared against each command word the sequencer issues.
module tb_servo_waypoint_sequencer;

   localparam int DEPTH   = 4;
   localparam int TOL     = 2;
   localparam int SETTLE  = 16;
   localparam int TIMEOUT = 300;
   localparam int CW      = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset, wp_valid, wp_ready, start, abort, busy, done, error;
   logic [11:0]   wp_angle;
   logic [1:0]    wp_mode;
   logic [7:0]    wp_period;
   logic [15:0]   wp_dwell;
   logic [31:0]   status_reg, ctrl_reg;
   logic [CW-1:0] fifo_count;

   typedef struct {
      logic [11:0] angle;
      logic [1:0]  mode;
      logic [7:0]  period;
   } wp_t;

   wp_t        sb_q[$];
   int         checks = 0, failures = 0;
   int         issues = 0, done_cnt = 0, err_cnt = 0;
   logic       tb_tgl = 1'b0;
   logic [1:0] prev_cmd = 2'b00;
   bit         track_en = 1'b0;

   servo_waypoint_sequencer #(.DEPTH(DEPTH), .TOL(TOL), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .wp_valid(wp_valid), .wp_ready(wp_ready),
      .wp_angle(wp_angle), .wp_mode(wp_mode), .wp_period(wp_period), .wp_dwell(wp_dwell),
      .start(start), .abort(abort), .status_reg(status_reg), .ctrl_reg(ctrl_reg),
      .busy(busy), .done(done), .error(error), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic logic [11:0] sat_m(input logic [11:0] a);
      return (a >= 12'd1006) ? 12'd1005 : a;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_wp(input logic [11:0] a, input logic [1:0] m, input logic [7:0] p,
                          input logic [15:0] d, output bit acc);
      wp_t w;
      @(negedge clk);
      wp_valid = 1'b1; wp_angle = a; wp_mode = m; wp_period = p; wp_dwell = d;
      #1 acc = wp_ready;
      if (acc) begin
         w.angle = a; w.mode = m; w.period = p;
         sb_q.push_back(w);
      end
      @(negedge clk);
      wp_valid = 1'b0;
   endtask

   task automatic start_run();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_move(input string tag);
      for (int i = 0; i < 20 && !ctrl_reg[31]; i++) @(negedge clk);
      chk(tag, ctrl_reg[31], 1);
   endtask

   task automatic wait_end(input string tag, input int max, output int k);
      k = 0;
      while (!(done || error) && k < max) begin
         @(negedge clk);
         k++;
      end
      chk(tag, done | error, 1);
   endtask

   // Scoreboard monitor: each new powered command word pops one queued waypoint.
   initial begin : monitor
      wp_t w;
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_cmd = 2'b00;
         end else begin
            if (ctrl_reg[31] && ctrl_reg[30:29] != prev_cmd) begin
               issues++;
               if (sb_q.size() == 0) begin
                  chk("issue_unexpected", ctrl_reg, 32'd0);
               end else begin
                  w = sb_q.pop_front();
                  e = {1'b1, 1'b1, tb_tgl, w.mode, 7'd0, w.period, sat_m(w.angle)};
                  tb_tgl = ~tb_tgl;
                  chk("issue_word", ctrl_reg, e);
               end
            end
            prev_cmd = ctrl_reg[30:29];
            if (done) begin
               done_cnt++;
               chk("done_busy_low", busy, 0);
            end
            if (error) begin
               err_cnt++;
               chk("error_busy_low", busy, 0);
            end
         end
      end
   end

   // Servo model: slews the current angle toward the commanded angle, 40 counts per cycle.
   initial begin : servo_model
      logic [11:0] c, t;
      forever begin
         @(negedge clk);
         if (track_en && ctrl_reg[31]) begin
            c = status_reg[11:0];
            t = ctrl_reg[11:0];
            if (c < t)      c = (t - c > 12'd40) ? c + 12'd40 : t;
            else if (c > t) c = (c - t > 12'd40) ? c - 12'd40 : t;
            status_reg = {20'd0, c};
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int  k, d0, e0, i0;
      bit  acc;
      reset = 1'b1; wp_valid = 1'b0; wp_angle = '0; wp_mode = '0; wp_period = '0;
      wp_dwell = '0; start = 1'b0; abort = 1'b0; status_reg = '0;
      tick(3);
      chk("rst_ctrl", ctrl_reg, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_fifo", fifo_count, 0);
      chk("rst_ready", wp_ready, 1);
      reset = 1'b0;
      tick(1);

      // Three tracked waypoints, start latency, single done pulse.
      track_en = 1'b1;
      d0 = done_cnt; e0 = err_cnt; i0 = issues;
      push_wp(12'd100, 2'b01, 8'd50, 16'd10, acc);
      push_wp(12'd500, 2'b01, 8'd50, 16'd10, acc);
      push_wp(12'd1000, 2'b01, 8'd50, 16'd10, acc);
      chk("t1_count", fifo_count, 3);
      @(negedge clk); start = 1'b1;
      chk("t1_idle_busy", busy, 0);
      @(negedge clk); start = 1'b0;
      chk("t1_load_busy", busy, 1);
      chk("t1_load_power", ctrl_reg[31], 0);
      @(negedge clk);
      chk("t1_move_hdr", ctrl_reg[31:29], 3'b110);
      wait_end("t1_end_seen", 2000, k);
      @(negedge clk);
      chk("t1_done_once", done_cnt - d0, 1);
      chk("t1_no_error", err_cnt - e0, 0);
      chk("t1_issues", issues - i0, 3);
      chk("t1_done_width", done, 0);
      chk("t1_idle_word", ctrl_reg, 32'd1000);
      chk("t1_busy", busy, 0);

      // Wrap-around arrival: target 2, current 1004 -> 1005 -> 0 -> 1, dwell 3.
      track_en = 1'b0;
      status_reg = 32'd500;
      push_wp(12'd2, 2'b00, 8'd10, 16'd3, acc);
      start_run();
      wait_move("t2_move");
      @(negedge clk); status_reg = 32'd1004;
      @(negedge clk); status_reg = 32'd1005;
      @(negedge clk); status_reg = 32'd0;
      k = 0;
      while (!(done || error) && k < 100) begin
         @(negedge clk);
         k++;
         status_reg = 32'd1;
      end
      chk("t2_arrive_dwell_cycles", k, SETTLE + 3 + 1);
      chk("t2_done", done, 1);

      // Oscillating in/out of window -> timeout with one waypoint still queued.
      status_reg = 32'd320;
      d0 = done_cnt; e0 = err_cnt;
      push_wp(12'd300, 2'b01, 8'd20, 16'd0, acc);
      push_wp(12'd600, 2'b01, 8'd20, 16'd0, acc);
      start_run();
      wait_move("t3_move");
      k = 0;
      while (!(done || error) && k < 1000) begin
         @(negedge clk);
         k++;
         status_reg = ((k / 5) % 2 != 0) ? 32'd301 : 32'd320;
      end
      chk("t3_timeout_cycles", k, TIMEOUT);
      chk("t3_error", error, 1);
      chk("t3_fifo_flushed", fifo_count, 0);
      chk("t3_busy", busy, 0);
      chk("t3_idle_word", ctrl_reg, 32'd300);
      sb_q.delete();
      @(negedge clk);
      chk("t3_error_width", error, 0);
      chk("t3_err_once", err_cnt - e0, 1);
      chk("t3_no_done", done_cnt - d0, 0);

      // Arrival in the last timeout cycle wins over the timeout.
      status_reg = 32'd320;
      d0 = done_cnt; e0 = err_cnt;
      push_wp(12'd300, 2'b01, 8'd20, 16'd0, acc);
      start_run();
      wait_move("t3b_move");
      k = 0;
      while (!(done || error) && k < 1000) begin
         @(negedge clk);
         k++;
         status_reg = (k >= TIMEOUT - SETTLE) ? 32'd300 : 32'd320;
      end
      chk("t3b_tie_cycles", k, TIMEOUT + 1);
      @(negedge clk);
      chk("t3b_no_error", err_cnt - e0, 0);
      chk("t3b_done", done_cnt - d0, 1);

      // FIFO full, push+pop in LOAD, angle saturation.
      track_en = 1'b1;
      d0 = done_cnt; i0 = issues;
      push_wp(12'd2000, 2'b01, 8'd30, 16'd2, acc);
      push_wp(12'd10, 2'b00, 8'd31, 16'd2, acc);
      push_wp(12'd20, 2'b01, 8'd32, 16'd2, acc);
      chk("t4_count3", fifo_count, 3);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wp_valid = 1'b1; wp_angle = 12'd30; wp_mode = 2'b00; wp_period = 8'd33; wp_dwell = 16'd2;
      #1 acc = wp_ready;
      chk("t4_ready_in_load", acc, 1);
      if (acc) sb_q.push_back('{angle: 12'd30, mode: 2'b00, period: 8'd33});
      @(negedge clk); wp_valid = 1'b0;
      chk("t4_pushpop_count", fifo_count, 3);
      push_wp(12'd40, 2'b01, 8'd34, 16'd2, acc);
      chk("t4_count_full", fifo_count, 4);
      chk("t4_ready_full", wp_ready, 0);
      push_wp(12'd50, 2'b01, 8'd35, 16'd2, acc);
      chk("t4_full_refused", acc, 0);
      chk("t4_count_still", fifo_count, 4);
      wait_end("t4_end_seen", 3000, k);
      @(negedge clk);
      chk("t4_issues", issues - i0, 5);
      chk("t4_done", done_cnt - d0, 1);
      chk("t4_idle_word", ctrl_reg, 32'd40);

      // Abort in MOVE with two waypoints queued.
      track_en = 1'b0;
      status_reg = 32'd600;
      d0 = done_cnt; e0 = err_cnt;
      push_wp(12'd100, 2'b01, 8'd40, 16'd0, acc);
      push_wp(12'd200, 2'b01, 8'd40, 16'd0, acc);
      push_wp(12'd300, 2'b01, 8'd40, 16'd0, acc);
      start_run();
      wait_move("t5_move");
      tick(3);
      chk("t5_queued", fifo_count, 2);
      abort = 1'b1;
      #1 chk("t5_ready_abort", wp_ready, 0);
      @(negedge clk); abort = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_fifo", fifo_count, 0);
      chk("t5_hdr", ctrl_reg[31:29], 3'b000);
      chk("t5_idle_angle", ctrl_reg[11:0], 100);
      chk("t5_done", done, 0);
      chk("t5_error", error, 0);
      sb_q.delete();
      tick(5);
      chk("t5_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

      // Reset during DWELL, then the next run starts again with cmd 10.
      status_reg = 32'd700;
      push_wp(12'd700, 2'b01, 8'd60, 16'd50, acc);
      start_run();
      wait_move("t6_move");
      tick(SETTLE + 5);
      chk("t6_in_dwell", busy, 1);
      reset = 1'b1;
      tb_tgl = 1'b0;
      sb_q.delete();
      @(negedge clk);
      chk("t6_rst_ctrl", ctrl_reg, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_done", done, 0);
      chk("t6_rst_error", error, 0);
      chk("t6_rst_fifo", fifo_count, 0);
      chk("t6_rst_ready", wp_ready, 1);
      reset = 1'b0;
      status_reg = 32'd500;
      d0 = done_cnt;
      push_wp(12'd500, 2'b01, 8'd70, 16'd0, acc);
      start_run();
      wait_move("t6_move2");
      chk("t6_first_cmd", ctrl_reg[30:29], 2'b10);
      wait_end("t6_end_seen", 500, k);
      @(negedge clk);
      chk("t6_done", done_cnt - d0, 1);
      chk("sb_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/servo_waypoint_sequencer.md
# servo_waypoint_sequencer

Sequences the servo controller unit through a queue of target angles. Buffers up to DEPTH waypoints, each with an angle, control mode, PWM period and dwell time. Drives the controller's 32-bit command word and watches the current-angle field of its status word to detect arrival, settle and timeout. Sits between the host/SPI register bank and the servo controller unit, replacing direct host writes of the command word.

## Interface
- DEPTH, 4: waypoint FIFO depth, power of 2, ≥2
- TOL, 2: arrival window, counts (circular distance)
- SETTLE, 16: consecutive in-window cycles required for arrival
- TIMEOUT, 2**24-1: max cycles in MOVE before error
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- wp_valid  in  1  waypoint offered
- wp_ready  out  1  FIFO can accept
- wp_angle  in  12  target angle, 0..1005
- wp_mode  in  2  control mode (00 bang-bang, 01 proportional)
- wp_period  in  8  PWM period
- wp_dwell  in  16  hold cycles after arrival
- start  in  1  level/pulse; begin run from IDLE
- abort  in  1  stop immediately
- status_reg  in  32  servo controller status; [11:0] = current angle
- ctrl_reg  out  32  servo controller command word
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse, queue completed
- error  out  1  one-cycle pulse, timeout
- fifo_count  out  $clog2(DEPTH)+1  stored waypoints

## Operation
- ctrl_reg fields: [31] power, [30:29] cmd, [28:27] mode, [19:12] period, [11:0] angle; all other bits 0.
- Servo controller latches a word only when cmd = 00 or cmd differs from the previous cycle. Each new waypoint is issued with cmd alternating 10/11 (toggle flag, reset 0 → first issue is 10). Idle word: power=0, cmd=00, mode/period 0, angle = last target.
- FIFO: push on wp_valid & wp_ready; wp_ready = (fifo_count < DEPTH) & ~abort. wp_angle ≥ 1006 is stored as 1005. Push and pop in the same cycle leave fifo_count unchanged. Pushes accepted in every state.
- Circular distance: d = |cur − tgt|; if d > 503 then d = 1006 − d. In-window when d ≤ TOL.
- States:
  - IDLE: start & fifo_count>0 → LOAD; start with empty FIFO ignored.
  - LOAD: pop head into target registers, toggle flag, clear settle/timeout/dwell counters → MOVE.
  - MOVE: ctrl_reg = {1, cmd, mode, period, angle}. Each cycle, in-window increments settle_cnt, else clears it. settle_cnt reaching SETTLE → DWELL. timeout_cnt increments every MOVE cycle; reaching TIMEOUT → error pulse, FIFO flushed → IDLE.
  - DWELL: ctrl_reg held; dwell_cnt counts to wp_dwell (0 = leave next cycle). Then fifo_count>0 → LOAD, else done pulse → IDLE.
- abort (any state, priority over all): next cycle state=IDLE, FIFO flushed, idle word driven, no done/error.
- reset: all state cleared, same as abort plus toggle flag=0 and angle field 0.

## Timing
- Reset values: ctrl_reg=0, wp_ready=1 (after reset), busy=0, done=0, error=0, fifo_count=0.
- All outputs registered. start sampled in cycle N → LOAD in N+1 → new ctrl_reg visible N+2.
- Arrival: first in-window status sample at cycle M, stable thereafter → DWELL entered at M+SETTLE.
- DWELL with dwell=D lasts D+1 cycles before LOAD/IDLE; LOAD→new word = 2 cycles between waypoints' ctrl_reg updates after dwell.
- done/error asserted exactly one cycle, same cycle busy falls.
- Timeout and arrival in the same cycle: arrival wins.

## Test plan
- Push 3 waypoints (100, 500, 1000; mode 01; dwell 10), start, model servo tracking → three ctrl_reg issues with cmd 10, 11, 10, power=1, done pulse once, ctrl_reg returns to idle word with angle 1000.
- Target 2, current sweeps 1004→1005→0→1 with TOL=2 → in-window from 1004 (wrap distance 4? no, 1005 d=3; 0 d=2) settle counts from 0-sample, DWELL after SETTLE cycles.
- Current oscillates in/out of window every 5 cycles, SETTLE=16 → never DWELL; TIMEOUT reached → error pulse, FIFO count 0, busy 0.
- Fill FIFO to DEPTH=4 → wp_ready=0; simultaneous push/pop during LOAD → fifo_count unchanged; wp_angle 2000 stored as 1005.
- abort asserted in MOVE with 2 queued → next cycle busy=0, fifo_count=0, ctrl_reg[31:29]=000, no done/error.
- reset asserted in DWELL → next cycle all outputs at reset values; subsequent run issues cmd 10 first.
